// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative radix-2 shift-add multiply and
// restoring divide, with sign fix-up, div-by-zero/overflow bypass.
module muldiv_unit #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [Width-1:0] rs1_val,
  input  logic [Width-1:0] rs2_val,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [Width-1:0] result,
  output logic [4:0]       rd_out,
  output logic             reg_write
);

  localparam int CW = $clog2(Width + 1);
  localparam logic [CW-1:0] LastCnt = CW'(Width - 1);
  localparam logic [Width-1:0] MinInt = {1'b1, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;
  logic [Width-1:0] opb_q, opb_d;
  logic [Width-1:0] result_q, result_d;

  logic             in_div;
  logic             sgn_a;
  logic             sgn_b;
  logic             a_neg;
  logic             b_neg;
  logic [Width-1:0] mag_a;
  logic [Width-1:0] mag_b;
  logic             div_zero;
  logic             div_ovf;

  logic [Width:0]   mul_sum;
  logic [Width:0]   div_sh;
  logic [Width:0]   div_diff;
  logic [Width-1:0] step_hi;
  logic [Width-1:0] step_lo;

  logic [2*Width-1:0] prod;
  logic [2*Width-1:0] prod_fix;
  logic [Width-1:0]   quo_fix;
  logic [Width-1:0]   rem_fix;
  logic [Width-1:0]   fix_res;

  // Request decode: operand signedness, magnitudes and bypass cases.
  always_comb begin
    in_div   = op[2];
    sgn_a    = (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b100) || (op == 3'b110);
    sgn_b    = (op == 3'b001) || (op == 3'b100) ||
               (op == 3'b110);
    a_neg    = sgn_a && rs1_val[Width-1];
    b_neg    = sgn_b && rs2_val[Width-1];
    mag_a    = a_neg ? ('0 - rs1_val) : rs1_val;
    mag_b    = b_neg ? ('0 - rs2_val) : rs2_val;
    div_zero = in_div && (rs2_val == '0);
    div_ovf  = in_div && !op[0] &&
               (rs1_val == MinInt) && (rs2_val == '1);
  end

  // One iteration of the shared multiply/divide datapath.
  always_comb begin
    mul_sum  = {1'b0, hi_q} +
               (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {hi_q, lo_q[Width-1]};
    div_diff = div_sh - {1'b0, opb_q};
    if (op_q[2]) begin
      if (!div_diff[Width]) begin
        step_hi = div_diff[Width-1:0];
        step_lo = {lo_q[Width-2:0], 1'b1};
      end else begin
        step_hi = div_sh[Width-1:0];
        step_lo = {lo_q[Width-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[Width:1];
      step_lo = {mul_sum[0], lo_q[Width-1:1]};
    end
  end

  // Sign correction and result selection for the FIX cycle.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (sa_q ^ sb_q) ? ('0 - prod) : prod;
    quo_fix  = (sa_q ^ sb_q) ? ('0 - lo_q) : lo_q;
    rem_fix  = sa_q ? ('0 - hi_q) : hi_q;
    fix_res  = '0;
    unique case (1'b1)
      (op_q == 3'b000): fix_res = prod_fix[Width-1:0];
      (op_q[2:1] == 2'b00 && op_q[0]),
      (op_q[2:1] == 2'b01): fix_res = prod_fix[2*Width-1:Width];
      (op_q[2:1] == 2'b10): fix_res = quo_fix;
      (op_q[2:1] == 2'b11): fix_res = rem_fix;
      default: fix_res = '0;
    endcase
  end

  // Next-state and datapath update; flush wins over everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            op_d  = op;
            rd_d  = rd_in;
            sa_d  = a_neg;
            sb_d  = b_neg;
            cnt_d = '0;
            hi_d  = '0;
            lo_d  = in_div ? mag_a : mag_b;
            opb_d = in_div ? mag_b : mag_a;
            if (div_zero) begin
              result_d = op[1] ? rs1_val : '1;
              state_d  = DONE;
            end else if (div_ovf) begin
              result_d = op[1] ? '0 : MinInt;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == LastCnt) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FIX: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE: begin
          if (res_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs; flush masks completion combinationally.
  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE) && !flush;
    reg_write   = res_valid && res_ready && (rd_q != '0);
    result      = result_q;
    rd_out      = rd_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops
// against an arithmetic reference, stall/flush/reset sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;

  int n_vec;
  int n_err;

  muldiv_unit #(.Width(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .rd_in       (rd_in),
    .flush       (flush),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .rd_out      (rd_out),
    .reg_write   (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    int ia;
    int ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) &&
        a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op (res_ready assumed 1) and report what came back.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] r, output logic [4:0] rdo,
                        output int lat, output logic rw);
    @(negedge clk);
    start_valid = 1'b1;
    op = o;
    rs1_val = a;
    rs2_val = b;
    rd_in = rd;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in = 5'($urandom);
    op = 3'($urandom);
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    rdo = rd_out;
    rw = reg_write;
    @(posedge clk);
    #1;
  endtask

  vec_t        vt[15];
  logic [31:0] r;
  logic [4:0]  rdo;
  int          lat;
  logic        rw;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [2:0]  ro;
  logic [4:0]  rr;
  int          cnt;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    op = '0;
    rs1_val = '0;
    rs2_val = '0;
    rd_in = '0;
    flush = 1'b0;
    res_ready = 1'b1;

    vt[0]  = '{3'd0, 32'd7, 32'd6, 5'd5, 32'h0000_002A, 34};
    vt[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0, 34};
    vt[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
               32'hFFFF_FFFE, 34};
    vt[3]  = '{3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 34};
    vt[4]  = '{3'd7, 32'd100, 32'd7, 5'd4, 32'd2, 34};
    vt[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 34};
    vt[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 34};
    vt[7]  = '{3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1};
    vt[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
               32'h8000_0000, 1};
    vt[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 1};
    vt[10] = '{3'd7, 32'd5, 32'd0, 5'd11, 32'd5, 1};
    vt[11] = '{3'd2, 32'hFFFF_FFFF, 32'd2, 5'd12, 32'hFFFF_FFFF, 34};
    vt[12] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, 34};
    vt[13] = '{3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 34};
    vt[14] = '{3'd6, 32'd9, 32'hFFFF_FFFC, 5'd31, 32'd1, 34};

    #12;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, r, rdo, lat, rw);
      check($sformatf("tbl%0d_result", i), r, vt[i].exp);
      check($sformatf("tbl%0d_rd", i), 32'(rdo), 32'(vt[i].rd));
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("tbl%0d_regw", i), 32'(rw),
            32'(vt[i].rd != 0));
    end

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rr = 5'($urandom);
      case ($urandom_range(0, 5))
        0: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
        1: begin ra = $urandom; rb = 32'h0; end
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: begin ra = $urandom; rb = 32'hFFFF_FFFF - $urandom_range(0, 5); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op(ro, ra, rb, rr, r, rdo, lat, rw);
      check($sformatf("rnd%0d_op%0d_result", i, ro), r,
            ref_model(ro, ra, rb));
      check($sformatf("rnd%0d_lat", i), 32'(lat),
            32'(ref_lat(ro, ra, rb)));
      check($sformatf("rnd%0d_regw", i), 32'(rw), 32'(rr != 0));
    end

    // Back-pressure: hold result in DONE for three cycles.
    res_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b1;
    op = 3'd0;
    rs1_val = 32'h0001_2345;
    rs2_val = 32'h0000_0100;
    rd_in = 5'd9;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("stall_valid", 32'(res_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("stall_result", result, 32'h0123_4500);
      check("stall_rd", 32'(rd_out), 32'd9);
      check("stall_start_ready", 32'(start_ready), 32'd0);
      check("stall_regw", 32'(reg_write), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("stall_release_regw", 32'(reg_write), 32'd1);
    @(posedge clk);
    #1;
    check("stall_after_valid", 32'(res_valid), 32'd0);
    check("stall_after_regw", 32'(reg_write), 32'd0);
    check("stall_after_ready", 32'(start_ready), 32'd1);

    // Flush in DONE beats the completion handshake.
    res_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b1;
    op = 3'd5;
    rs1_val = 32'd50;
    rs2_val = 32'd0;
    rd_in = 5'd3;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    check("fdone_valid", 32'(res_valid), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    res_ready = 1'b1;
    #1;
    check("fdone_valid_masked", 32'(res_valid), 32'd0);
    check("fdone_regw_masked", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("fdone_idle", 32'(start_ready), 32'd1);
    check("fdone_no_valid", 32'(res_valid), 32'd0);

    // Flush mid-CALC discards the operation.
    @(negedge clk);
    start_valid = 1'b1;
    op = 3'd0;
    rs1_val = 32'd11;
    rs2_val = 32'd13;
    rd_in = 5'd4;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fcalc_idle", 32'(start_ready), 32'd1);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid) cnt++;
    end
    check("fcalc_no_result", 32'(cnt), 32'd0);

    // Flush together with start_valid in IDLE must not accept.
    @(negedge clk);
    flush = 1'b1;
    start_valid = 1'b1;
    op = 3'd0;
    rs1_val = 32'd2;
    rs2_val = 32'd2;
    rd_in = 5'd2;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start_valid = 1'b0;
    check("fidle_no_accept", 32'(start_ready), 32'd1);

    // Async reset at CALC iteration 10.
    run_op(3'd0, 32'd21, 32'd2, 5'd6, r, rdo, lat, rw);
    check("prerst_result", r, 32'd42);
    @(negedge clk);
    start_valid = 1'b1;
    op = 3'd0;
    rs1_val = 32'h0000_FFFF;
    rs2_val = 32'h0000_FFFF;
    rd_in = 5'd7;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_start_ready", 32'(start_ready), 32'd1);
    check("mrst_res_valid", 32'(res_valid), 32'd0);
    check("mrst_reg_write", 32'(reg_write), 32'd0);
    check("mrst_result", result, 32'd0);
    check("mrst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid || reg_write) cnt++;
    end
    check("mrst_no_wb", 32'(cnt), 32'd0);
    run_op(3'd0, 32'd3, 32'd3, 5'd8, r, rdo, lat, rw);
    check("postrst_result", r, 32'd9);
    check("postrst_lat", 32'(lat), 32'd34);
    check("postrst_rd", 32'(rdo), 32'd8);
    check("postrst_regw", 32'(rw), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
